// File: rtl/sim_mem_pkg.sv
// Shared constants, pipeline entry type and helper functions for the
// simulation-only memory bridge in front of RAMHelper.
package sim_mem_pkg;

   localparam int          WORD_W            = 64;
   localparam int          WORD_BYTES        = 8;
   localparam int          CH_MAX_W          = 3;
   localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic                valid;
      logic [CH_MAX_W-1:0] ch;
      logic [2:0]          off;
      logic [WORD_W-1:0]   data;
   } pipe_entry_t;

   localparam pipe_entry_t PIPE_IDLE = {(1 + CH_MAX_W + 3 + WORD_W){1'b0}};

   function automatic int ch_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [WORD_W-1:0] expand_strb(input logic [WORD_BYTES-1:0] strb);
      logic [WORD_W-1:0] mask;
      mask = {WORD_W{1'b0}};
      for (int b = 0; b < WORD_BYTES; b++) begin
         mask[b*8 +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/sim_mem_rsp_fifo.sv
// Per-channel synchronous response FIFO; the head is presented combinationally
// and reads as zero while the FIFO is empty.
module sim_mem_rsp_fifo_chk (
   input logic clock,
   input logic reset,
   input logic push,
   input logic full
);
   // Upstream credits must make a push into a full FIFO impossible.
   assert property (@(posedge clock) disable iff (reset) !(push && full));
endmodule

module sim_mem_rsp_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 64,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (count_r == FULL_CNT);
   assign push_ok_s = push && !full_s;
   assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
   assign count     = count_r;
   assign head_data = (count_r != {CNT_W{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

   // Storage array, written at the tail.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   sim_mem_rsp_fifo_chk u_chk (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .full  (full_s)
   );

endmodule

// File: rtl/sim_mem_bridge.sv
// Round-robin front end sharing one RAMHelper port among NUM_CH cmd/rsp channels,
// with a fixed read latency and credit-limited per-channel response FIFOs.
module sim_mem_bridge
   import sim_mem_pkg::*;
#(
   parameter int          NUM_CH     = 2,
   parameter int          DATA_W     = 64,
   parameter int          IDX_W      = 28,
   parameter logic [63:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          LATENCY    = 1,
   parameter int          RSP_DEPTH  = 4,
   parameter logic [7:0]  ALIGN_MASK = 8'b0000_0001
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    cmd_valid,
   output logic [NUM_CH-1:0]    cmd_ready,
   input  logic [NUM_CH*64-1:0] cmd_addr,
   input  logic [NUM_CH-1:0]    cmd_wen,
   input  logic [NUM_CH*64-1:0] cmd_wdata,
   input  logic [NUM_CH*8-1:0]  cmd_wstrb,
   output logic [NUM_CH-1:0]    rsp_valid,
   input  logic [NUM_CH-1:0]    rsp_ready,
   output logic [NUM_CH*64-1:0] rsp_data,
   output logic                 ram_en,
   output logic [IDX_W-1:0]     ram_idx,
   input  logic [DATA_W-1:0]    ram_rdata,
   output logic                 ram_wen,
   output logic [DATA_W-1:0]    ram_wdata,
   output logic [DATA_W-1:0]    ram_wmask
);
   localparam int             CH_W    = ch_id_w(NUM_CH);
   localparam int             CNT_W   = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(RSP_DEPTH);

   logic [NUM_CH-1:0] elig_s, req_s, grant_s, rd_grant_s, push_s, pop_s;
   logic [CH_W-1:0]   rr_ptr_r, grant_idx_s, rr_next_s;
   logic              grant_any_s;
   logic [CNT_W-1:0]  inflight_r  [NUM_CH];
   logic [CNT_W-1:0]  fifo_cnt_s  [NUM_CH];
   logic [DATA_W-1:0] fifo_head_s [NUM_CH];
   logic [63:0]       sel_addr_s, sel_wdata_s, addr_off_s;
   logic [7:0]        sel_wstrb_s;
   logic              sel_wen_s;
   logic              unused_addr_bits_s;
   pipe_entry_t       sample_s, push_entry_s;
   logic [DATA_W-1:0] push_data_s;

   // Credit check: FIFO occupancy plus reads still in the delay line.
   always_comb begin
      elig_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         elig_s[i] = cmd_wen[i] ||
                     (({1'b0, fifo_cnt_s[i]} + {1'b0, inflight_r[i]}) < DEPTH_L);
      end
      req_s = cmd_valid & elig_s & {NUM_CH{~reset}};
   end

   // Round-robin pick: first requester at or after rr_ptr, wrapping.
   always_comb begin
      int idx_v;
      grant_any_s = 1'b0;
      grant_idx_s = {CH_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         idx_v = int'(rr_ptr_r) + k;
         idx_v = (idx_v >= NUM_CH) ? idx_v - NUM_CH : idx_v;
         if (!grant_any_s && req_s[idx_v]) begin
            grant_any_s = 1'b1;
            grant_idx_s = CH_W'(idx_v);
         end else begin
            grant_any_s = grant_any_s;
         end
      end
   end

   assign grant_s     = grant_any_s ? (NUM_CH'(1) << grant_idx_s) : {NUM_CH{1'b0}};
   assign rd_grant_s  = grant_s & ~cmd_wen;
   assign cmd_ready   = grant_s;
   assign rr_next_s   = (grant_idx_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}}
                                                           : grant_idx_s + CH_W'(1);
   assign sel_addr_s  = cmd_addr[grant_idx_s*64 +: 64];
   assign sel_wdata_s = cmd_wdata[grant_idx_s*64 +: 64];
   assign sel_wstrb_s = cmd_wstrb[grant_idx_s*8 +: 8];
   assign sel_wen_s   = cmd_wen[grant_idx_s];
   assign addr_off_s  = sel_addr_s - BASE_ADDR;
   assign unused_addr_bits_s = ^{addr_off_s[63:IDX_W+3], addr_off_s[2:0]};

   // RAMHelper port is driven only in the grant cycle.
   always_comb begin
      ram_en    = grant_any_s;
      ram_wen   = grant_any_s && sel_wen_s;
      ram_idx   = grant_any_s ? addr_off_s[IDX_W+2:3] : {IDX_W{1'b0}};
      ram_wdata = ram_wen ? sel_wdata_s : {DATA_W{1'b0}};
      ram_wmask = ram_wen ? expand_strb(sel_wstrb_s) : {DATA_W{1'b0}};
   end

   assign sample_s.valid = grant_any_s && !sel_wen_s;
   assign sample_s.ch    = CH_MAX_W'(grant_idx_s);
   assign sample_s.off   = sel_addr_s[2:0];
   assign sample_s.data  = ram_rdata;

   generate
      if (LATENCY == 1) begin : g_lat1
         assign push_entry_s = sample_s;
      end else begin : g_latn
         pipe_entry_t pipe_r [LATENCY-1];
         // Read delay line; a reset drops every in-flight read.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < LATENCY - 1; k++) pipe_r[k] <= PIPE_IDLE;
            end else begin
               pipe_r[0] <= sample_s;
               for (int k = 1; k < LATENCY - 1; k++) pipe_r[k] <= pipe_r[k-1];
            end
         end
         assign push_entry_s = pipe_r[LATENCY-2];
      end
   endgenerate

   assign push_data_s = ALIGN_MASK[push_entry_s.ch]
                      ? (push_entry_s.data >> {push_entry_s.off, 3'b000})
                      : push_entry_s.data;

   // Route the delay-line output to its channel FIFO.
   always_comb begin
      push_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         push_s[i] = push_entry_s.valid && (push_entry_s.ch == CH_MAX_W'(i));
      end
   end

   assign pop_s = rsp_valid & rsp_ready;

   // Arbitration pointer and per-channel in-flight read counts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_r <= {CH_W{1'b0}};
         for (int i = 0; i < NUM_CH; i++) inflight_r[i] <= {CNT_W{1'b0}};
      end else begin
         rr_ptr_r <= grant_any_s ? rr_next_s : rr_ptr_r;
         for (int i = 0; i < NUM_CH; i++) begin
            case ({rd_grant_s[i], push_s[i]})
               2'b10:   inflight_r[i] <= inflight_r[i] + CNT_W'(1);
               2'b01:   inflight_r[i] <= inflight_r[i] - CNT_W'(1);
               default: inflight_r[i] <= inflight_r[i];
            endcase
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sim_mem_rsp_fifo #(
         .DEPTH (RSP_DEPTH),
         .WIDTH (DATA_W)
      ) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (push_s[i]),
         .push_data (push_data_s),
         .pop       (pop_s[i]),
         .head_data (fifo_head_s[i]),
         .count     (fifo_cnt_s[i])
      );
      assign rsp_valid[i]         = (fifo_cnt_s[i] != {CNT_W{1'b0}});
      assign rsp_data[i*64 +: 64] = fifo_head_s[i];
   end

endmodule

// File: tb/tb_sim_mem_bridge.sv
// Directed bench for sim_mem_bridge: one LATENCY=1 instance with a RAM model,
// one LATENCY=4 instance reading a pattern source.
module tb_sim_mem_bridge;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

   logic         clock, reset, mem_init;
   logic [1:0]   cmd_valid, cmd_ready, cmd_wen, rsp_valid, rsp_ready;
   logic [127:0] cmd_addr, cmd_wdata, rsp_data;
   logic [15:0]  cmd_wstrb;
   logic         ram_en, ram_wen;
   logic [27:0]  ram_idx;
   logic [63:0]  ram_rdata, ram_wdata, ram_wmask;
   logic [63:0]  mem [16];

   logic [1:0]   cmd4_valid, cmd4_ready, cmd4_wen, rsp4_valid, rsp4_ready;
   logic [127:0] cmd4_addr, cmd4_wdata, rsp4_data;
   logic [15:0]  cmd4_wstrb;
   logic         ram4_en, ram4_wen;
   logic [27:0]  ram4_idx;
   logic [63:0]  ram4_rdata, ram4_wdata_unused, ram4_wmask_unused;

   int vectors, miscompares;

   sim_mem_bridge #(.NUM_CH(2), .LATENCY(1), .RSP_DEPTH(4), .ALIGN_MASK(8'h01)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_wen(cmd_wen), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .ram_en(ram_en), .ram_idx(ram_idx), .ram_rdata(ram_rdata), .ram_wen(ram_wen),
      .ram_wdata(ram_wdata), .ram_wmask(ram_wmask));

   sim_mem_bridge #(.NUM_CH(2), .LATENCY(4), .RSP_DEPTH(4), .ALIGN_MASK(8'h00)) dut4 (
      .clock(clock), .reset(reset), .cmd_valid(cmd4_valid), .cmd_ready(cmd4_ready),
      .cmd_addr(cmd4_addr), .cmd_wen(cmd4_wen), .cmd_wdata(cmd4_wdata), .cmd_wstrb(cmd4_wstrb),
      .rsp_valid(rsp4_valid), .rsp_ready(rsp4_ready), .rsp_data(rsp4_data),
      .ram_en(ram4_en), .ram_idx(ram4_idx), .ram_rdata(ram4_rdata), .ram_wen(ram4_wen),
      .ram_wdata(ram4_wdata_unused), .ram_wmask(ram4_wmask_unused));

   function automatic logic [63:0] init_word(input int i);
      if (i == 0) return 64'h1111_2222_3333_4444;
      return {16'hD0D0, i[15:0], 16'h5A5A, i[15:0]};
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign ram_rdata  = mem[ram_idx[3:0]];
   assign ram4_rdata = {32'hFEED_0000, 4'h0, ram4_idx};

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else if (ram_en && ram_wen) begin
         mem[ram_idx[3:0]] <= (mem[ram_idx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) step();
      cmd_valid = 2'b11; cmd4_valid = 2'b11; cmd_addr = {BASE, BASE}; #1;
      vectors++; if (cmd_ready !== 2'b00) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 00", cmd_ready); end
      vectors++; if (cmd4_ready !== 2'b00) begin miscompares++; $display("FAIL rst_cmd4_ready: got %b want 00", cmd4_ready); end
      vectors++; if (ram_en !== 1'b0 || ram_wen !== 1'b0) begin miscompares++; $display("FAIL rst_ram_en: got %b/%b want 0/0", ram_en, ram_wen); end
      vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
      vectors++; if (rsp_data !== 128'h0) begin miscompares++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
      cmd_valid = 2'b00; cmd4_valid = 2'b00; mem_init = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_align_read();
      rsp_ready = 2'b11; cmd_wen = 2'b00;
      cmd_valid = 2'b01; cmd_addr[63:0] = 64'h8000_0004; #1;
      vectors++; if (cmd_ready !== 2'b01) begin miscompares++; $display("FAIL align_ready: got %b want 01", cmd_ready); end
      vectors++; if (ram_en !== 1'b1 || ram_idx !== 28'h0) begin miscompares++; $display("FAIL align_ram: got en=%b idx=%h want en=1 idx=0", ram_en, ram_idx); end
      step();
      cmd_valid = 2'b00; #1;
      vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL align_rsp_valid: got %b want 01", rsp_valid); end
      vectors++; if (rsp_data[63:0] !== 64'h0000_0000_1111_2222) begin miscompares++; $display("FAIL align_rsp_data: got %h want 0000000011112222", rsp_data[63:0]); end
      step();
      vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL align_pop: got %b want 00", rsp_valid); end
   endtask

   task automatic test_write_readback();
      cmd_valid = 2'b10; cmd_wen = 2'b10; cmd_addr[127:64] = 64'h8000_0010;
      cmd_wdata[127:64] = 64'hAABB_CCDD_0000_0000; cmd_wstrb[15:8] = 8'hF0; #1;
      vectors++; if (cmd_ready !== 2'b10) begin miscompares++; $display("FAIL wr_ready: got %b want 10", cmd_ready); end
      vectors++; if (ram_wen !== 1'b1 || ram_idx !== 28'h2) begin miscompares++; $display("FAIL wr_ram: got wen=%b idx=%h want wen=1 idx=2", ram_wen, ram_idx); end
      vectors++; if (ram_wmask !== 64'hFFFF_FFFF_0000_0000) begin miscompares++; $display("FAIL wr_mask: got %h want ffffffff00000000", ram_wmask); end
      vectors++; if (ram_wdata !== 64'hAABB_CCDD_0000_0000) begin miscompares++; $display("FAIL wr_data: got %h want aabbccdd00000000", ram_wdata); end
      step();
      cmd_wen = 2'b00; #1;
      vectors++; if (cmd_ready !== 2'b10 || ram_wen !== 1'b0) begin miscompares++; $display("FAIL raw_ready: got %b wen=%b want 10 wen=0", cmd_ready, ram_wen); end
      vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL wr_no_rsp: got %b want 00", rsp_valid); end
      step();
      cmd_valid = 2'b00; #1;
      vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("FAIL raw_rsp_valid: got %b want 10", rsp_valid); end
      vectors++; if (rsp_data[127:64] !== 64'hAABB_CCDD_5A5A_0002) begin miscompares++; $display("FAIL raw_rsp_data: got %h want aabbccdd5a5a0002", rsp_data[127:64]); end
      step();
   endtask

   task automatic test_round_robin();
      int n0, n1;
      logic [1:0]  exp_g, prev_g;
      logic [63:0] prev_w, got_w;
      n0 = 0; n1 = 0; prev_g = 2'b00; prev_w = 64'h0;
      cmd_wen = 2'b00; rsp_ready = 2'b11;
      for (int c = 0; c < 7; c++) begin
         cmd_valid = (c < 6) ? 2'b11 : 2'b00;
         cmd_addr[63:0]   = BASE + 64'(8 * (3 + n0));
         cmd_addr[127:64] = BASE + 64'(8 * (8 + n1));
         #1;
         if (c > 0) begin
            got_w = (prev_g == 2'b01) ? rsp_data[63:0] : rsp_data[127:64];
            vectors++; if (rsp_valid !== prev_g) begin miscompares++; $display("FAIL rr_rsp_valid c=%0d: got %b want %b", c, rsp_valid, prev_g); end
            vectors++; if (got_w !== prev_w) begin miscompares++; $display("FAIL rr_rsp_data c=%0d: got %h want %h", c, got_w, prev_w); end
         end
         if (c < 6) begin
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            vectors++; if (cmd_ready !== exp_g) begin miscompares++; $display("FAIL rr_grant c=%0d: got %b want %b", c, cmd_ready, exp_g); end
            prev_g = exp_g;
            if (exp_g == 2'b01) begin prev_w = init_word(3 + n0); n0++; end
            else begin prev_w = init_word(8 + n1); n1++; end
         end
         step();
      end
   endtask

   task automatic test_credit();
      int k;
      logic [1:0] exp_r;
      k = 0; rsp_ready = 2'b00; cmd_wen = 2'b00;
      for (int c = 0; c < 12; c++) begin
         if (c == 6) rsp_ready = 2'b01;
         cmd_valid = (c <= 7) ? 2'b01 : 2'b00;
         cmd_addr[63:0] = BASE + 64'(8 * (11 + k));
         #1;
         if (c <= 7) begin
            exp_r = (c < 4 || c == 7) ? 2'b01 : 2'b00;
            vectors++; if (cmd_ready !== exp_r) begin miscompares++; $display("FAIL credit_ready c=%0d: got %b want %b", c, cmd_ready, exp_r); end
            if (exp_r == 2'b01) k++;
         end
         if (c >= 6 && c <= 10) begin
            vectors++; if (rsp_valid !== 2'b01 || rsp_data[63:0] !== init_word(11 + c - 6)) begin
               miscompares++; $display("FAIL credit_rsp c=%0d: got %b %h want 01 %h", c, rsp_valid, rsp_data[63:0], init_word(11 + c - 6)); end
         end else if (c == 11) begin
            vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL credit_drain: got %b want 00", rsp_valid); end
         end
         step();
      end
   endtask

   task automatic test_latency4();
      int k;
      logic [1:0]  exp_v;
      logic [63:0] exp_d;
      k = 0; rsp4_ready = 2'b11; cmd4_wen = 2'b00;
      for (int c = 0; c < 9; c++) begin
         cmd4_valid = (c < 4) ? 2'b01 : 2'b00;
         cmd4_addr[63:0] = BASE + 64'(8 * (20 + k));
         #1;
         if (c < 4) begin
            vectors++; if (cmd4_ready !== 2'b01 || ram4_en !== 1'b1 || ram4_wen !== 1'b0) begin
               miscompares++; $display("FAIL lat4_grant c=%0d: got rdy=%b en=%b wen=%b want 01 1 0", c, cmd4_ready, ram4_en, ram4_wen); end
            k++;
         end
         exp_v = (c >= 4 && c <= 7) ? 2'b01 : 2'b00;
         vectors++; if (rsp4_valid !== exp_v) begin miscompares++; $display("FAIL lat4_valid c=%0d: got %b want %b", c, rsp4_valid, exp_v); end
         if (exp_v == 2'b01) begin
            exp_d = {32'hFEED_0000, 4'h0, 28'(20 + c - 4)};
            vectors++; if (rsp4_data[63:0] !== exp_d) begin miscompares++; $display("FAIL lat4_data c=%0d: got %h want %h", c, rsp4_data[63:0], exp_d); end
         end
         step();
      end
   endtask

   task automatic test_reset_inflight();
      rsp4_ready = 2'b00; cmd4_wen = 2'b00;
      for (int c = 0; c < 4; c++) begin
         cmd4_valid = (c == 1) ? 2'b00 : 2'b01;
         cmd4_addr[63:0] = BASE + 64'(8 * (24 + c));
         step();
      end
      cmd4_valid = 2'b00; #1;
      vectors++; if (rsp4_valid !== 2'b01) begin miscompares++; $display("FAIL pre_rst_occupancy: got %b want 01", rsp4_valid); end
      reset = 1'b1; #1;
      vectors++; if (rsp4_valid !== 2'b00) begin miscompares++; $display("FAIL rst_inflight_valid: got %b want 00", rsp4_valid); end
      vectors++; if (rsp4_data !== 128'h0) begin miscompares++; $display("FAIL rst_inflight_data: got %h want 0", rsp4_data); end
      step();
      reset = 1'b0; rsp4_ready = 2'b11;
      for (int c = 0; c < 8; c++) begin
         step();
         vectors++; if (rsp4_valid !== 2'b00) begin miscompares++; $display("FAIL stale_rsp c=%0d: got %b want 00", c, rsp4_valid); end
      end
      cmd4_valid = 2'b11; #1;
      vectors++; if (cmd4_ready !== 2'b01) begin miscompares++; $display("FAIL rr_after_reset: got %b want 01", cmd4_ready); end
      step();
      cmd4_valid = 2'b00;
      repeat (8) step();
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      reset = 1'b1; mem_init = 1'b1;
      cmd_valid = 2'b00; cmd_wen = 2'b00; cmd_addr = 128'h0; cmd_wdata = 128'h0;
      cmd_wstrb = 16'h0; rsp_ready = 2'b00;
      cmd4_valid = 2'b00; cmd4_wen = 2'b00; cmd4_addr = 128'h0; cmd4_wdata = 128'h0;
      cmd4_wstrb = 16'h0; rsp4_ready = 2'b00;
      test_reset();
      test_align_read();
      test_write_readback();
      test_round_robin();
      test_credit();
      test_latency4();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
